// File: rtl/sar_pkg.sv
// Shared types for the SAR controller: FSM state encoding and comparator decision decode.
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SET,
        CMP,
        DONE
    } sar_state_t;

    // Comparator decision classes
    typedef enum logic [1:0] {
        KEEP,
        CLEAR,
        UNRESOLVED
    } sar_dec_t;

    // Map the differential comparator pair onto a decision class
    function automatic sar_dec_t decode_cmp(input logic dout, input logic doutb);
        sar_dec_t dec;
        case ({dout, doutb})
            2'b10:   dec = KEEP;
            2'b01:   dec = CLEAR;
            default: dec = UNRESOLVED;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/sar_logic.sv
// sar_logic: successive-approximation controller. Tracks the input for TSMP
// cycles, then for each bit (MSB first) presents a trial code to the DAC for
// TSET cycles, clocks the comparator for TCMP cycles and registers its decision
// on the last comparator-clock cycle. Publishes the N-bit result with a one-cycle done.
// Ports:
//   clk, rstn          clock, async active-low reset
//   start              conversion request (honoured in IDLE only)
//   cmp_dout/cmp_doutb comparator differential decision
//   cmp_clk            comparator clock
//   sample             track/hold control (high while tracking)
//   dac_code           trial code to the capacitive DAC
//   busy, done         conversion in progress / result-update pulse
//   result             last completed conversion
//   meta_err           an unresolved decision occurred in the last conversion
module sar_logic
    import sar_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned TSMP = 2,
    parameter int unsigned TSET = 1,
    parameter int unsigned TCMP = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic         cmp_dout,
    input  logic         cmp_doutb,
    output logic         cmp_clk,
    output logic         sample,
    output logic [N-1:0] dac_code,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         meta_err
);

    localparam int unsigned PMAX = (TSMP > TSET) ? ((TSMP > TCMP) ? TSMP : TCMP)
                                                 : ((TSET > TCMP) ? TSET : TCMP);
    localparam int unsigned PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam int unsigned KW   = $clog2(N);
    localparam logic [N-1:0] MSB_BIT = {1'b1, {(N-1){1'b0}}};

    sar_state_t     state;
    logic [PW-1:0]  phase;
    logic [KW-1:0]  k;
    logic [N-1:0]   code;   // decided bits only; the trial bit is not stored here

    sar_dec_t       dec_c;
    logic [N-1:0]   bit_mask_c;
    logic [N-1:0]   next_mask_c;
    logic [N-1:0]   code_next_c;

    // Decision decode and code update for the bit under test
    always_comb begin
        dec_c       = decode_cmp(cmp_dout, cmp_doutb);
        bit_mask_c  = N'(1) << k;
        next_mask_c = bit_mask_c >> 1;
        code_next_c = (dec_c == KEEP) ? (code | bit_mask_c) : code;
    end

    // Controller FSM with registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            phase    <= '0;
            k        <= '0;
            code     <= '0;
            cmp_clk  <= 1'b0;
            sample   <= 1'b0;
            dac_code <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            meta_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SAMPLE;
                        sample   <= 1'b1;
                        busy     <= 1'b1;
                        phase    <= '0;
                        code     <= '0;
                        dac_code <= '0;
                        meta_err <= 1'b0;
                    end
                end
                SAMPLE: begin
                    if (phase == PW'(TSMP - 1)) begin
                        state    <= SET;
                        sample   <= 1'b0;
                        phase    <= '0;
                        k        <= KW'(N - 1);
                        dac_code <= MSB_BIT;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                SET: begin
                    if (phase == PW'(TSET - 1)) begin
                        state   <= CMP;
                        cmp_clk <= 1'b1;
                        phase   <= '0;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                CMP: begin
                    // Decision is taken only on the last regeneration cycle
                    if (phase == PW'(TCMP - 1)) begin
                        cmp_clk  <= 1'b0;
                        phase    <= '0;
                        code     <= code_next_c;
                        meta_err <= meta_err | (dec_c == UNRESOLVED);
                        if (k != '0) begin
                            k        <= k - KW'(1);
                            state    <= SET;
                            dac_code <= code_next_c | next_mask_c;
                        end else begin
                            state    <= DONE;
                            dac_code <= code_next_c;
                            result   <= code_next_c;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_logic.sv
// Bench for sar_logic (N=4, TSMP=2, TSET=1, TCMP=2) with an ideal comparator
// model and a done-triggered scoreboard.
module tb_sar_logic;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic         cmp_dout;
    logic         cmp_doutb;
    logic         cmp_clk;
    logic         sample;
    logic [N-1:0] dac_code;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         meta_err;

    always #5 clk = ~clk;

    sar_logic #(.N(N), .TSMP(2), .TSET(1), .TCMP(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .cmp_dout  (cmp_dout),
        .cmp_doutb (cmp_doutb),
        .cmp_clk   (cmp_clk),
        .sample    (sample),
        .dac_code  (dac_code),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .meta_err  (meta_err)
    );

    typedef struct packed {
        logic [N-1:0] res;
        logic         me;
    } exp_t;

    exp_t sb_q[$];
    int   target    = 0;
    int   unres_bit = -1;
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   done_cnt  = 0;

    // Trial bit of a code is its lowest set bit (lower bits are still zero)
    function automatic int low_bit(input logic [N-1:0] v);
        for (int i = 0; i < int'(N); i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Ideal comparator, optionally forced unresolved on one bit
    always_comb begin
        if (unres_bit >= 0 && low_bit(dac_code) == unres_bit) begin
            cmp_dout  = 1'b1;
            cmp_doutb = 1'b1;
        end else begin
            cmp_dout  = (target >= int'(dac_code));
            cmp_doutb = ~cmp_dout;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmp_clk"},  int'(cmp_clk),  0);
        chk({tag, "_sample"},   int'(sample),   0);
        chk({tag, "_busy"},     int'(busy),     0);
        chk({tag, "_done"},     int'(done),     0);
        chk({tag, "_dac_code"}, int'(dac_code), 0);
        chk({tag, "_result"},   int'(result),   0);
        chk({tag, "_meta_err"}, int'(meta_err), 0);
    endtask

    // Scoreboard monitor: every done pulse consumes one expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            chk("busy_with_done", int'(busy), 0);
            chk("no_x", int'($isunknown({result, dac_code, meta_err, busy, sample, cmp_clk})), 0);
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("result",   int'(result),   int'(e.res));
                chk("meta_err", int'(meta_err), int'(e.me));
                chk("dac_hold", int'(dac_code), int'(e.res));
            end
        end
    end

    // One conversion; timing=1 adds latency/busy/trial checks for target 10
    task automatic convert(input int tgt, input int ubit, input int exp_res, input bit exp_me,
                           input bit timing, input bit extra_start);
        int   cyc, busy_n, done_cyc, ntr;
        int   tr[8];
        int   exp_tr[4];
        logic prev_cc;
        exp_t e;
        exp_tr    = '{8, 12, 10, 11};
        target    = tgt;
        unres_bit = ubit;
        e.res     = N'(exp_res);
        e.me      = exp_me;
        sb_q.push_back(e);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1; busy_n = 0; done_cyc = 0; ntr = 0; prev_cc = 1'b0;
        while (done_cyc == 0 && cyc <= 40) begin
            if (busy) busy_n++;
            if (cmp_clk && !prev_cc && ntr < 8) begin
                tr[ntr] = int'(dac_code);
                ntr++;
            end
            prev_cc = cmp_clk;
            if (done) begin
                done_cyc = cyc;
            end else begin
                start = extra_start && (cyc == 2 || cyc == 8);
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (done_cyc == 0) begin
            chk("done_timeout", 0, 1);
        end else if (timing) begin
            chk("done_cycle",  done_cyc, 15);
            chk("busy_cycles", busy_n,   14);
            chk("n_trials",    ntr,      4);
            if (ntr == 4) begin
                for (int i = 0; i < 4; i++) chk("trial", tr[i], exp_tr[i]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int d0, dones, last_done, cyc, w;
        logic prev_s;
        exp_t e;

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Directed conversions
        convert(10, -1, 10, 1'b0, 1'b1, 1'b0);
        convert(0,  -1, 0,  1'b0, 1'b0, 1'b0);
        convert(15, -1, 15, 1'b0, 1'b0, 1'b0);
        convert(15,  2, 11, 1'b1, 1'b0, 1'b0);
        convert(7,  -1, 7,  1'b0, 1'b0, 1'b0);

        // Start pulses during a conversion are ignored
        d0 = done_cnt;
        convert(9, -1, 9, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("single_done", done_cnt - d0, 1);

        // Start held high: back-to-back conversions with one IDLE cycle
        target = 6; unres_bit = -1;
        dones = 0; last_done = -1; cyc = 0; prev_s = 1'b0;
        e.res = N'(6); e.me = 1'b0;
        start = 1'b1;
        while (dones < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (sample && !prev_s) begin
                sb_q.push_back(e);
                if (last_done >= 0) chk("idle_gap", cyc - last_done, 2);
            end
            prev_s = sample;
            if (done) begin
                dones++;
                last_done = cyc;
                if (dones == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("held_dones", dones, 3);
        repeat (5) @(negedge clk);

        // Reset during CMP of bit 1
        target = 9;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        w = 0;
        while (!(cmp_clk && dac_code[1:0] == 2'b10) && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) chk("reach_bit1", 0, 1);
        rstn = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        convert(5, -1, 5, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sar_logic.md
# sar_logic

Synchronous successive-approximation controller for the SAR ADC. It drives the clock of the comparator's clocked sense amplifier and captures that comparator's differential decision (`dout`/`doutb`). From each decision it builds the DAC trial code MSB-first, then publishes an N-bit result with a one-cycle `done` pulse. It sits between the comparator (below) and the ADC's digital back end (above).

## Interface
Parameters:
- `N`, 8: conversion resolution in bits (≥2).
- `TSMP`, 2: cycles with `sample` high (track phase), ≥1.
- `TSET`, 1: cycles per bit with `cmp_clk` low: comparator reset plus DAC settling, ≥1.
- `TCMP`, 2: cycles per bit with `cmp_clk` high: regeneration window, ≥1.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rstn`  in  1  reset; asynchronous assertion, active-low.
- `start`  in  1  conversion request, sampled in IDLE only.
- `cmp_dout`  in  1  comparator output; 1 means vin > vdac.
- `cmp_doutb`  in  1  comparator complementary output.
- `cmp_clk`  out  1  comparator clock; rising edge triggers a decision.
- `sample`  out  1  track/hold control; high while tracking.
- `dac_code`  out  N  trial code to the capacitive DAC.
- `busy`  out  1  high from the accepted start until `done`.
- `done`  out  1  one-cycle pulse when `result` updates.
- `result`  out  N  last completed conversion; held until the next `done`.
- `meta_err`  out  1  set if any bit in the last conversion was unresolved.

## Operation
- States: IDLE, SAMPLE, SET, CMP, DONE. A phase counter (width clog2(max(TSMP,TSET,TCMP))) and a bit index `k` (N-1 down to 0).
- IDLE: `busy`=0, `cmp_clk`=0, `sample`=0. When `start`=1, go to SAMPLE. This clears `meta_err` and the internal code register.
- SAMPLE: `sample`=1 for TSMP cycles. Then go to SET with k=N-1.
- SET: `dac_code` = code | (1<<k), `cmp_clk`=0, for TSET cycles. Then go to CMP.
- CMP: `cmp_clk`=1 for TCMP cycles. On the last CMP edge, register the decision:
  - `cmp_dout`=1 and `cmp_doutb`=0: keep bit k.
  - `cmp_dout`=0 and `cmp_doutb`=1: clear bit k.
  - `cmp_dout`==`cmp_doutb` (unresolved): clear bit k and set `meta_err`.
- After CMP: if k>0, decrement k and go to SET. If k=0, go to DONE.
- DONE: one cycle. `result` <= final code, `done`=1, `busy`=0, `dac_code` holds the final code. Then go to IDLE.
- `start` outside IDLE is ignored; no queuing. `start` held high causes back-to-back conversions, because IDLE lasts ≥1 cycle.
- The comparator output is sampled only on the last CMP edge, so `dout` values during reset or regeneration never reach the code register.

## Timing
- Reset values: `cmp_clk`=0, `sample`=0, `busy`=0, `done`=0, `dac_code`=0, `result`=0, `meta_err`=0, state=IDLE.
- All outputs are registered; no combinational path from `cmp_dout` to any output.
- `start` is seen at edge E0. `sample` and `busy` go high after E0.
- `busy` stays high for TSMP + N·(TSET+TCMP) cycles. `done` is high in the cycle after that. `busy` and `done` are never high together.
- The decision for bit k is visible in `dac_code` from the next SET entry.
- Reset mid-conversion: immediate return to reset values. The partial code is discarded and `result` is cleared.

## Structure
- Shared package `sar_pkg` holds:
  - state enum `sar_state_t` (IDLE, SAMPLE, SET, CMP, DONE);
  - the decision-encoding constants (KEEP, CLEAR, UNRESOLVED).
- No sub-module is required. The phase counter and bit index are inline.
- For behavioural simulation, the bench pairs this block with the existing comparator model plus a DAC model.

## Test plan
All scenarios use N=4, TSMP=2, TSET=1, TCMP=2 unless stated. An ideal bench comparator gives `cmp_dout` = (target ≥ `dac_code`).
- target=10 -> trials 8, 12, 10, 11; `result`=4'b1010; `done` exactly 15 cycles after the start edge; `busy` high for 14 cycles; `meta_err`=0.
- target=0 and target=15 -> `result`=0 and 15 respectively; no X on any output.
- Bit 2 forced `cmp_dout`=`cmp_doutb`=1, target=15 -> `result`=4'b1011; `meta_err`=1. The next clean conversion clears `meta_err`.
- `start` pulsed at cycles 3 and 9 of a conversion -> ignored; exactly one `done`.
- `start` held high -> consecutive conversions with one IDLE cycle between each `done` and the next `sample` rise.
- `rstn` low during CMP of bit 1 -> all outputs at reset values within the same cycle. A new start after release gives a correct result.
